decoder_scan: RTL and testbench
===============================

// Module: decoder_scan
// PURPOSE
//  Parametrised, registered N-to-2^N one-hot decoder with enable, polarity select and a
//  built-in auto-scan mode.
//  Direct mode decodes sel_in. Scan mode steps the selected line on its own, for example
//  to drive multiplexed 7-segment anodes.
//  Sits between control logic and display or chip-select fan-out.
// PARAMETERS
//  SEL_W      2  select width; output width is 2**SEL_W (legal 1..5)
//  ACTIVE_LOW 0  1: active output line is 0 and inactive lines are 1
//  SCAN_DIV   4  clk cycles per scan step (legal >=1); prescaler width is clog2(SCAN_DIV), min 1
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous, active-low reset
//  en        in   1          1: decode active; 0: all lines inactive, state held
//  mode      in   1          0: direct decode of sel_in; 1: auto-scan
//  sel_in    in   SEL_W      direct-mode select; also the scan start index
//  scan_max  in   SEL_W      highest scan index before wrapping to 0
//  dec_out   out  2**SEL_W   registered one-hot (or one-cold) decode
//  cur_sel   out  SEL_W      registered index currently driven on dec_out
//  step      out  1          1-cycle pulse in the cycle cur_sel advances in scan mode
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - dec_out = all inactive (0s, or 1s if ACTIVE_LOW); cur_sel=0; step=0.
//   - Prescaler=0; internal mode_q=0.
//  All outputs are registered. No combinational path from inputs to outputs.
//  Direct mode (mode=1'b0, en=1'b1):
//   - Latency 1 clk: cur_sel<=sel_in; dec_out<=decode(sel_in).
//   - Prescaler held at 0; step=0.
//  Scan entry: mode_q=0 and mode=1 with en=1.
//   - cur_sel<=sel_in and prescaler<=0 on that edge; dec_out follows.
//   - step=0 on entry.
//  Scan run (mode=1, mode_q=1, en=1):
//   - The prescaler counts 0..SCAN_DIV-1.
//   - At the terminal count: prescaler<=0; cur_sel<=next; step<=1 for that cycle only.
//   - next = (cur_sel>=scan_max) ? 0 : cur_sel+1. If cur_sel>scan_max (scan_max lowered
//     mid-scan), the step goes to 0.
//   - scan_max=0: index stays 0 but step still pulses every SCAN_DIV cycles.
//   - SCAN_DIV=1: step=1 every cycle and the index advances every cycle.
//   - The index wraps 2**SEL_W-1 -> 0 when scan_max is all ones.
//  Scan exit (mode 1->0):
//   - Next edge is a direct-mode update.
//   - Prescaler<=0; step=0.
//  en=0 (either mode):
//   - Next edge: dec_out<=all inactive; step<=0.
//   - cur_sel, prescaler and mode_q hold.
//   - mode_q does not update while en=0, so a mode change made while disabled is seen as
//     an entry or exit when en returns to 1.
//   - en back to 1 in scan mode resumes from the held cur_sel and prescaler.
//  dec_out is always decode(cur_sel) while en=1.
//  Exactly one line is active when enabled. No line is active when disabled.
//  Async reset mid-scan clears all state immediately.
//  Counting restarts from the scan-entry rule after rst_n deasserts.
//  Implementation:
//   - mode_q is a register of mode, updated only when en=1.
//   - The decode is a generate loop comparing cur_sel against index i.
// TESTING
//  1 Reset: rst_n=0 with en=1, mode=1 -> dec_out=0000, cur_sel=0, step=0, asynchronously
//    (before the next clk edge).
//  2 Direct, SEL_W=2: sel_in=2 -> dec_out=0100 one clk later.
//    With ACTIVE_LOW=1 -> 1011. Check all 4 codes.
//  3 Scan, SCAN_DIV=4, scan_max=3, sel_in=1 at entry:
//    - cur_sel=1, 2, 3, 0, 1; each held for exactly 4 clks.
//    - step pulses 1 clk wide, 4 clks apart.
//  4 Scan with scan_max=2 -> sequence 0,1,2,0.
//    Drop scan_max to 0 while cur_sel=2 -> next step goes to 0 and stays 0;
//    step keeps pulsing.
//  5 en=0 for 3 clks mid-scan (prescaler=2):
//    - dec_out=0000 and step=0 throughout.
//    - After en=1: same cur_sel, and the advance comes 2 clks later.
//  6 Assert rst_n=0 mid-scan and release -> outputs cleared.
//    Scan restarts at sel_in with a full SCAN_DIV before the first step.
//    Repeat at SEL_W=3 and SCAN_DIV=1 (advance every clk, 8-way wrap).

Source files
------------

// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: control/select inputs and the registered decode outputs.
// The master drives en/mode/sel_in/scan_max; the decoder (slave) returns dec_out/cur_sel/step.
interface decoder_scan_if #(
  parameter int SEL_W = 2
);
  localparam int N = 1 << SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic [SEL_W-1:0] scan_max;
  logic [N-1:0]     dec_out;
  logic [SEL_W-1:0] cur_sel;
  logic             step;

  modport master (
    output en, mode, sel_in, scan_max,
    input  dec_out, cur_sel, step
  );

  modport slave (
    input  en, mode, sel_in, scan_max,
    output dec_out, cur_sel, step
  );
endinterface

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot/one-cold decoder with enable and an auto-scan mode
// that steps the selected line every SCAN_DIV clocks up to scan_max, then wraps.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_DIRECT | last enabled cycle was direct mode (mode_q=0); next scan
//           | request is a scan entry that loads sel_in
// ST_SCAN   | scan running; prescaler advances, index steps at terminal
module decoder_scan #(
  parameter int SEL_W      = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int SCAN_DIV   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_scan_if.slave  bus
);
  localparam int N  = 1 << SEL_W;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  DEC_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [PW-1:0]    presc_q, presc_nxt;
  logic             step_q, step_nxt;
  logic [N-1:0]     dec_q, dec_nxt;
  logic [N-1:0]     dec_hot;

  // state register (this is mode_q)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_DIRECT;
    end else begin
      state <= state_nxt;
    end
  end

  // mode is only tracked while enabled, so a change made while disabled
  // is seen as an entry/exit once en returns
  always_comb begin
    state_nxt = state;
    if (bus.en) begin
      state_nxt = bus.mode ? ST_SCAN : ST_DIRECT;
    end
  end

  always_comb begin
    sel_nxt   = sel_q;
    presc_nxt = presc_q;
    step_nxt  = 1'b0;
    if (bus.en) begin
      if (!bus.mode) begin
        sel_nxt   = bus.sel_in;
        presc_nxt = '0;
      end else begin
        case (state)
          ST_DIRECT: begin
            sel_nxt   = bus.sel_in;
            presc_nxt = '0;
          end
          ST_SCAN: begin
            if (presc_q == PRESC_TC) begin
              presc_nxt = '0;
              step_nxt  = 1'b1;
              // covers scan_max lowered below the current index as well as the top-end wrap
              sel_nxt   = (sel_q >= bus.scan_max) ? '0 : sel_q + SEL_W'(1);
            end else begin
              presc_nxt = presc_q + PW'(1);
            end
          end
          default: begin
            sel_nxt   = bus.sel_in;
            presc_nxt = '0;
          end
        endcase
      end
    end
  end

  // decode the index being loaded so dec_out always matches cur_sel
  for (genvar i = 0; i < N; i++) begin : g_dec
    assign dec_hot[i] = (sel_nxt == SEL_W'(i));
  end

  always_comb begin
    dec_nxt = DEC_IDLE;
    if (bus.en) begin
      dec_nxt = (ACTIVE_LOW != 0) ? ~dec_hot : dec_hot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      presc_q <= '0;
      step_q  <= 1'b0;
      dec_q   <= DEC_IDLE;
    end else begin
      sel_q   <= sel_nxt;
      presc_q <= presc_nxt;
      step_q  <= step_nxt;
      dec_q   <= dec_nxt;
    end
  end

  assign bus.dec_out = dec_q;
  assign bus.cur_sel = sel_q;
  assign bus.step    = step_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three instances (2-bit active-high, 2-bit active-low, 3-bit
// SCAN_DIV=1) share stimulus and are compared against a cycle-level model every clock.
module tb_decoder_scan;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       en    = 1'b1;
  logic       mode  = 1'b1;
  logic [2:0] sel   = 3'd0;
  logic [2:0] smax  = 3'd0;

  int n_chk  = 0;
  int n_fail = 0;

  decoder_scan_if #(.SEL_W(2)) if_a ();
  decoder_scan_if #(.SEL_W(2)) if_b ();
  decoder_scan_if #(.SEL_W(3)) if_c ();

  assign if_a.en = en;  assign if_a.mode = mode;
  assign if_a.sel_in = sel[1:0];  assign if_a.scan_max = smax[1:0];
  assign if_b.en = en;  assign if_b.mode = mode;
  assign if_b.sel_in = sel[1:0];  assign if_b.scan_max = smax[1:0];
  assign if_c.en = en;  assign if_c.mode = mode;
  assign if_c.sel_in = sel;       assign if_c.scan_max = smax;

  decoder_scan #(.SEL_W(2), .ACTIVE_LOW(0), .SCAN_DIV(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  decoder_scan #(.SEL_W(2), .ACTIVE_LOW(1), .SCAN_DIV(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  decoder_scan #(.SEL_W(3), .ACTIVE_LOW(0), .SCAN_DIV(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  always #5 clk = ~clk;

  // reference model: index, cycles since last advance, scan flag, enable-lit, step
  int m_sw [3] = '{2, 2, 3};
  int m_al [3] = '{0, 1, 0};
  int m_div[3] = '{4, 4, 1};
  int m_idx[3];
  int m_cnt[3];
  bit m_scan[3];
  bit m_lit[3];
  bit m_stp[3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_scan[k] = 0; m_lit[k] = 0; m_stp[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    int mask, s, mx;
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      mask = (1 << m_sw[k]) - 1;
      s  = int'(sel) & mask;
      mx = int'(smax) & mask;
      m_stp[k] = 0;
      if (!en) begin
        m_lit[k] = 0;
      end else begin
        m_lit[k] = 1;
        if (!mode || !m_scan[k]) begin
          m_idx[k] = s; m_cnt[k] = 0; m_scan[k] = mode;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == m_div[k]) begin
            m_cnt[k] = 0;
            m_stp[k] = 1;
            m_idx[k] = (m_idx[k] >= mx) ? 0 : m_idx[k] + 1;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_one(input int k, input logic [31:0] dec, input logic [31:0] cs, input logic [31:0] stp);
    logic [31:0] mask, hot, exp_dec;
    mask = (32'd1 << (1 << m_sw[k])) - 32'd1;
    hot  = 32'd1 << m_idx[k];
    if (m_lit[k]) exp_dec = (m_al[k] != 0) ? (~hot & mask) : hot;
    else          exp_dec = (m_al[k] != 0) ? mask : 32'd0;
    chk($sformatf("model%0d dec_out", k), dec, exp_dec);
    chk($sformatf("model%0d cur_sel", k), cs, 32'(m_idx[k]));
    chk($sformatf("model%0d step", k), stp, 32'(m_stp[k]));
  endtask

  task automatic check_model();
    check_one(0, 32'(if_a.dec_out), 32'(if_a.cur_sel), 32'(if_a.step));
    check_one(1, 32'(if_b.dec_out), 32'(if_b.cur_sel), 32'(if_b.step));
    check_one(2, 32'(if_c.dec_out), 32'(if_c.cur_sel), 32'(if_c.step));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // independent hand check of instance a while enabled
  task automatic chk_a(input string nm, input int cs, input int stp);
    chk({nm, " cur_sel"}, 32'(if_a.cur_sel), 32'(cs));
    chk({nm, " step"}, 32'(if_a.step), 32'(stp));
    chk({nm, " dec_out"}, 32'(if_a.dec_out), 32'd1 << cs);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic [1:0] cs;
    logic [3:0] dec_a;
    logic [3:0] dec_b;
  } vec_t;

  vec_t vt[6];
  int   seq3[5] = '{1, 2, 3, 0, 1};
  int   seq4[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    vt[0] = '{1'b1, 2'd0, 2'd0, 4'b0001, 4'b1110};
    vt[1] = '{1'b1, 2'd1, 2'd1, 4'b0010, 4'b1101};
    vt[2] = '{1'b1, 2'd2, 2'd2, 4'b0100, 4'b1011};
    vt[3] = '{1'b1, 2'd3, 2'd3, 4'b1000, 4'b0111};
    vt[4] = '{1'b0, 2'd1, 2'd3, 4'b0000, 4'b1111};
    vt[5] = '{1'b1, 2'd2, 2'd2, 4'b0100, 4'b1011};

    // async reset with en=1, mode=1, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("reset dec_a", 32'(if_a.dec_out), 32'h0);
    chk("reset dec_b", 32'(if_b.dec_out), 32'hF);
    chk("reset cur_sel", 32'(if_a.cur_sel), 32'h0);
    chk("reset step", 32'(if_a.step), 32'h0);
    check_model();
    tick();
    rst_n = 1'b1;
    mode  = 1'b0;

    // direct decode table
    for (int i = 0; i < 6; i++) begin
      en  = vt[i].en;
      sel = {1'b0, vt[i].sel};
      tick();
      chk($sformatf("vec%0d dec_a", i), 32'(if_a.dec_out), 32'(vt[i].dec_a));
      chk($sformatf("vec%0d dec_b", i), 32'(if_b.dec_out), 32'(vt[i].dec_b));
      chk($sformatf("vec%0d cur_sel", i), 32'(if_a.cur_sel), 32'(vt[i].cs));
      chk($sformatf("vec%0d step", i), 32'(if_a.step), 32'h0);
    end

    // scan from 1 up to 3 and wrap, 4 clocks per index
    en = 1'b1; sel = 3'd1; smax = 3'd3; mode = 1'b1;
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_a("scan3", seq3[k], (c == 0 && k > 0) ? 1 : 0);
      end

    // scan_max=2, then lowered to 0 while index is 2
    mode = 1'b0; sel = 3'd0;
    tick();
    mode = 1'b1; smax = 3'd2;
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_a("scan4", seq4[k], (c == 0 && k > 0) ? 1 : 0);
        if (k == 5 && c == 1) smax = 3'd0;
      end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_a("scan4 max0", 0, (c == 0) ? 1 : 0);
      end

    // disable for 3 clocks with prescaler at 2
    smax = 3'd3;
    tick(); chk_a("pre-dis adv", 1, 1);
    tick(); tick(); chk_a("pre-dis hold", 1, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis dec_a", 32'(if_a.dec_out), 32'h0);
      chk("dis dec_b", 32'(if_b.dec_out), 32'hF);
      chk("dis step", 32'(if_a.step), 32'h0);
      chk("dis cur_sel", 32'(if_a.cur_sel), 32'h1);
    end
    en = 1'b1;
    tick(); chk_a("resume hold", 1, 0);
    tick(); chk_a("resume adv", 2, 1);

    // async reset mid-scan, then restart at sel_in (instance c: 8-way every clock)
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst dec_a", 32'(if_a.dec_out), 32'h0);
    chk("midrst cur_sel", 32'(if_a.cur_sel), 32'h0);
    chk("midrst step", 32'(if_a.step), 32'h0);
    chk("midrst dec_b", 32'(if_b.dec_out), 32'hF);
    sel = 3'd5; smax = 3'd7;
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("restart entry", 1, 0);
    chk("restart c cur_sel", 32'(if_c.cur_sel), 32'd5);
    chk("restart c step", 32'(if_c.step), 32'd0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("wrap c cur_sel", 32'(if_c.cur_sel), 32'((5 + j) % 8));
      chk("wrap c dec_out", 32'(if_c.dec_out), 32'd1 << ((5 + j) % 8));
      chk("wrap c step", 32'(if_c.step), 32'd1);
      chk_a("restart a", (j < 4) ? 1 : ((j < 8) ? 2 : 3), (j == 4 || j == 8) ? 1 : 0);
    end

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        #1 rst_n = 1'b1;
      end
      en  = ($urandom_range(0, 99) < 88);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      sel = 3'($urandom);
      if ($urandom_range(0, 39) == 0) smax = 3'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
